// File: rtl/wb_stage_pkg.sv
// Shared definitions for the MEM/WB writeback stage: load type encodings and
// default widths used by wb_stage and load_align.
package wb_stage_pkg;

  localparam int WIDTH_DEF      = 32;
  localparam int ADDR_WIDTH_DEF = 5;

  typedef logic [2:0] ld_type_t;

  localparam ld_type_t LD_LW  = 3'd0;
  localparam ld_type_t LD_LB  = 3'd1;
  localparam ld_type_t LD_LBU = 3'd2;
  localparam ld_type_t LD_LH  = 3'd3;
  localparam ld_type_t LD_LHU = 3'd4;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational sub-word load alignment and extension, little-endian.
// Misaligned halfword/word loads report misalign and return zero data.
module load_align
  import wb_stage_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] rdata,
  input  logic [1:0]       off,
  input  logic [2:0]       ld_type,
  output logic [WIDTH-1:0] data,
  output logic             misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{off, 3'b000} +: 8];
  assign half_sel = rdata[{off[1], 4'b0000} +: 16];

  // NOTE: both outputs get a default first so no path leaves them unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    data     = '0;
    misalign = 1'b0;
    case (ld_type)
      LD_LB:  data = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      LD_LBU: data = {{(WIDTH-8){1'b0}}, byte_sel};
      LD_LH: begin
        misalign = off[0];
        if (!off[0]) data = {{(WIDTH-16){half_sel[15]}}, half_sel};
      end
      LD_LHU: begin
        misalign = off[0];
        if (!off[0]) data = {{(WIDTH-16){1'b0}}, half_sel};
      end
      // LW and the unused encodings 5-7 all behave as a full-word load.
      default: begin
        misalign = (off != 2'd0);
        if (off == 2'd0) data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback stage driving the register file write
// port. Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_in,
  input  logic                  flush_in,
  input  logic                  mem_valid,
  input  logic                  mem_regwrite,
  input  logic                  mem_memtoreg,
  input  logic [2:0]            mem_ld_type,
  input  logic [ADDR_WIDTH-1:0] mem_dst,
  input  logic [WIDTH-1:0]      mem_alu_result,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic                  RegWrite,
  output logic [ADDR_WIDTH-1:0] Write_register,
  output logic [WIDTH-1:0]      Write_data,
  output logic                  fwd_valid,
  output logic                  wb_misalign
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]           retire_count
`endif
);

  logic [WIDTH-1:0]      ld_data;
  logic                  ld_mis;
  logic [WIDTH-1:0]      next_data;
  logic                  next_mis;

  logic                  valid_q;
  logic                  regwrite_q;
  logic                  misalign_q;
  logic                  written_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [WIDTH-1:0]      data_q;

  load_align #(.WIDTH(WIDTH)) u_load_align (
    .rdata    (mem_rdata),
    .off      (mem_alu_result[1:0]),
    .ld_type  (mem_ld_type),
    .data     (ld_data),
    .misalign (ld_mis)
  );

  // Selection happens before the register so outputs are straight flop outputs.
  assign next_mis  = mem_memtoreg & ld_mis;
  assign next_data = mem_memtoreg ? ld_data : mem_alu_result;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      misalign_q <= 1'b0;
      written_q  <= 1'b0;
      dst_q      <= '0;
      data_q     <= '0;
    end else if (flush_in) begin
      valid_q <= 1'b0;
    end else if (stall_in) begin
      // A stalled entry writes once; later stall cycles only forward.
      written_q <= written_q | RegWrite;
    end else begin
      valid_q    <= mem_valid;
      regwrite_q <= mem_regwrite;
      misalign_q <= next_mis;
      written_q  <= 1'b0;
      dst_q      <= mem_dst;
      data_q     <= next_data;
    end
  end

  assign fwd_valid      = valid_q & regwrite_q & (dst_q != '0) & ~misalign_q;
  assign RegWrite       = fwd_valid & ~written_q;
  assign Write_register = dst_q;
  assign Write_data     = data_q;
  assign wb_misalign    = valid_q & misalign_q;

`ifdef WB_RETIRE_CNT_EN
  logic retired_q;
  logic retire_now;

  // retired_q marks an entry already counted during its first stall cycle.
  assign retire_now = valid_q & ~misalign_q & ~flush_in & ~retired_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_count <= '0;
      retired_q    <= 1'b0;
    end else begin
      if (retire_now) retire_count <= retire_count + 32'd1;
      if (!flush_in) begin
        if (stall_in) retired_q <= retired_q | retire_now;
        else          retired_q <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register and writeback stage of the 5-stage MIPS core.
- Sits directly upstream of the register file and drives its write port (RegWrite, Write_register, Write_data).
- Selects between the ALU result and load data, aligning and extending sub-word loads.
- Exports a forwarding bus and a misaligned-load flag for the hazard unit.

Parameters:
- WIDTH, 32, data width.
- ADDR_WIDTH, 5, register index width.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- stall_in  in  1  hold the current WB entry; do not capture from MEM.
- flush_in  in  1  invalidate the entry captured this cycle.
- mem_valid  in  1  MEM stage presents a valid instruction.
- mem_regwrite  in  1  instruction writes a GPR.
- mem_memtoreg  in  1  1 = write load data, 0 = write ALU result.
- mem_ld_type  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5-7 treated as LW.
- mem_dst  in  ADDR_WIDTH  destination register.
- mem_alu_result  in  WIDTH  ALU result, which is also the load address.
- mem_rdata  in  WIDTH  raw aligned data memory word.
- RegWrite  out  1  register file write enable.
- Write_register  out  ADDR_WIDTH  register file write index.
- Write_data  out  WIDTH  register file write data.
- fwd_valid  out  1  WB holds a valid pending result for forwarding.
- wb_misalign  out  1  current entry is a misaligned load.

Behaviour:
- Reset (async, reset=1):
  - Clear valid, written and misalign state.
  - Outputs: RegWrite=0, Write_register=0, Write_data=0, fwd_valid=0, wb_misalign=0.
  - Reset asserted mid-operation discards the entry immediately; no write issues.
- Capture on posedge clk:
  - Priority is flush_in > stall_in > load.
  - flush_in=1: valid<=0, regardless of stall_in.
  - stall_in=1 (no flush): all state holds.
  - Otherwise:
    - valid<=mem_valid.
    - Register the dst index and write data.
    - Set misalign from the rules below.
    - Clear written.
- Latency: a value presented in MEM in cycle N appears on Write_data in cycle N+1.
- Data selection is computed before capture, so outputs come straight from registers.
  - memtoreg=0: data=mem_alu_result.
  - Otherwise, with off=mem_alu_result[1:0], little-endian:
    - LB / LBU: byte = rdata[8*off+7 : 8*off], sign- or zero-extended to 32 bits.
    - LH / LHU: half = rdata[16*off[1]+15 : 16*off[1]], sign- or zero-extended.
    - LW: the full word.
- Misalign rules (checked only when memtoreg=1):
  - LH/LHU with off[0]=1.
  - LW with off!=0.
  - A misaligned entry forces data=0.
- RegWrite = valid & regwrite & (dst!=0) & !misalign & !written.
  - written sets on any clock edge where RegWrite=1 and stall_in=1.
  - So a stalled entry writes exactly once.
- Write to r0: RegWrite stays 0, and fwd_valid=0 for dst=0.
- fwd_valid = valid & regwrite & (dst!=0) & !misalign.
  - It stays high through a stall even after the write has issued.
- wb_misalign = valid & misalign. It is level-held while the entry stalls.
- Simultaneous flush_in and stall_in: flush wins.
- mem_valid=0 capture: a bubble; all enables low, data registers may update.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - Add output retire_count (32 bits), reset to 0.
  - It increments by 1 on each edge where an entry leaves WB:
    - valid=1, !misalign, and not being flushed;
    - and either stall_in=0, or the first stall cycle for that entry.
    - Each entry is counted once. Bubbles are not counted.
  - It wraps from 32'hFFFFFFFF to 0.
- Undefined: no port, no counter logic.

Decomposition:
- Shared package / include file holds:
  - load type encodings (LD_LW=0, LD_LB=1, LD_LBU=2, LD_LH=3, LD_LHU=4);
  - WIDTH and ADDR_WIDTH defaults.
- Sub-module load_align (combinational): inputs rdata, off, ld_type; outputs data and misalign. It is reused by any future cache fill path.

Test Plan:
- ALU writeback: mem_valid=1, regwrite=1, memtoreg=0, dst=8, alu=32'h12345678 -> next cycle RegWrite=1, Write_register=8, Write_data=32'h12345678, fwd_valid=1.
- LB sign-extend: rdata=32'h80FF7F01, alu=...0001, ld_type=LB -> Write_data=32'h0000007F. With off=2 -> 32'hFFFFFFFF. LBU, off=3 -> 32'h00000080.
- Misaligned LH: alu=...0003, ld_type=LH, dst=5 -> wb_misalign=1, RegWrite=0, fwd_valid=0, Write_data=0.
- Stall single-write: capture dst=9 data=32'hA5A5A5A5, hold stall_in=1 for 3 cycles -> RegWrite high in the first cycle only, fwd_valid high all 3 cycles, outputs unchanged.
- Flush vs stall plus r0: flush_in=1 with stall_in=1 -> valid=0 next cycle. dst=0 with regwrite=1 -> RegWrite=0, fwd_valid=0.
- Async reset: assert reset between clock edges while RegWrite=1 -> RegWrite, Write_data and fwd_valid drop to 0 immediately. With WB_RETIRE_CNT_EN, retire_count=0 after 5 retirements and a reset.
